// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting one functional-unit
// completion per cycle onto a registered common data bus (CDB).
//
// Parameters:
//   N_REQ  - number of completion requesters (2..8)
//   TAG_W  - ROB tag width
//   DATA_W - result value width
//
// Ports:
//   clock          - system clock, rising edge
//   reset          - asynchronous active-low reset
//   squash         - ROB flush; blocks grant and broadcast this cycle
//   req_valid      - per-requester result pending
//   req_tag        - per-requester tag, slice [i*TAG_W +: TAG_W]
//   req_value      - per-requester value, slice [i*DATA_W +: DATA_W]
//   req_ack        - one-hot combinational grant
//   cdb_valid      - registered broadcast valid
//   cdb_tag        - registered broadcast tag
//   cdb_value      - registered broadcast value
//   cdb_src        - requester index of current broadcast
//   grant_count    - broadcasts issued (CDB_ARB_PERF_EN only)
//   conflict_count - cycles with >=2 requests, no squash
//                    (CDB_ARB_PERF_EN only)
//
// Optional feature macro: CDB_ARB_PERF_EN

module cdb_arbiter #(
   parameter int N_REQ  = 4,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     squash,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*TAG_W-1:0]   req_tag,
   input  logic [N_REQ*DATA_W-1:0]  req_value,
   output logic [N_REQ-1:0]         req_ack,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_value,
   output logic [$clog2(N_REQ)-1:0] cdb_src
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [31:0]              grant_count,
   output logic [31:0]              conflict_count
`endif
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
   localparam logic [PW:0]   NSUM = (PW+1)'(N_REQ);

   logic [PW-1:0]     r_ptr;
   logic              r_cdb_valid;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_value;
   logic [PW-1:0]     r_cdb_src;

   logic [PW:0]       w_sum;
   logic [PW-1:0]     w_gnt;
   logic              w_any;
   logic              w_take;
   logic [N_REQ-1:0]  w_ack;
   logic [PW-1:0]     w_ptr_nxt;

   // Walk the priority ring from lowest to highest priority so
   // the last hit (offset 0 = r_ptr) wins.  The sum fits PW+1
   // bits since 2*(N_REQ-1) < 2^(PW+1).
   always_comb begin
      w_sum = '0;
      w_gnt = '0;
      w_any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= NSUM) begin
            w_sum = w_sum - NSUM;
         end
         if (req_valid[w_sum[PW-1:0]]) begin
            w_any = 1'b1;
            w_gnt = w_sum[PW-1:0];
         end
      end
   end

   // Squash and reset both suppress the grant outright, so the
   // requester keeps its result and is re-arbitrated later.
   always_comb begin
      w_take = w_any & ~squash & reset;
      w_ack  = '0;
      if (w_take) begin
         w_ack = N_REQ'(1) << w_gnt;
      end
      if (w_gnt == LAST) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_gnt + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_value <= '0;
         r_cdb_src   <= '0;
      end else begin
         r_cdb_valid <= w_take;
         if (w_take) begin
            r_ptr       <= w_ptr_nxt;
            r_cdb_tag   <= req_tag[w_gnt*TAG_W +: TAG_W];
            r_cdb_value <= req_value[w_gnt*DATA_W +: DATA_W];
            r_cdb_src   <= w_gnt;
         end
      end
   end

   assign req_ack   = w_ack;
   assign cdb_valid = r_cdb_valid;
   assign cdb_tag   = r_cdb_tag;
   assign cdb_value = r_cdb_value;
   assign cdb_src   = r_cdb_src;

`ifdef CDB_ARB_PERF_EN
   logic [31:0] r_grant_cnt;
   logic [31:0] r_conf_cnt;
   logic        w_multi;

   // Clearing the lowest set bit leaves a residue only when two
   // or more bits were set.
   assign w_multi = |(req_valid & (req_valid - N_REQ'(1)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_grant_cnt <= '0;
         r_conf_cnt  <= '0;
      end else begin
         if (w_take) begin
            r_grant_cnt <= r_grant_cnt + 32'd1;
         end
         if (w_multi && !squash) begin
            r_conf_cnt <= r_conf_cnt + 32'd1;
         end
      end
   end

   assign grant_count    = r_grant_cnt;
   assign conflict_count = r_conf_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector bench for cdb_arbiter
// (N_REQ=4, TAG_W=5, DATA_W=32).

module tb_cdb_arbiter;

   logic         clock;
   logic         reset;
   logic         squash;
   logic [3:0]   req_valid;
   logic [19:0]  req_tag;
   logic [127:0] req_value;
   logic [3:0]   req_ack;
   logic         cdb_valid;
   logic [4:0]   cdb_tag;
   logic [31:0]  cdb_value;
   logic [1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
   logic [31:0]  grant_count;
   logic [31:0]  conflict_count;
`endif

   cdb_arbiter #(
      .N_REQ (4),
      .TAG_W (5),
      .DATA_W(32)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .req_valid(req_valid),
      .req_tag  (req_tag),
      .req_value(req_value),
      .req_ack  (req_ack),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_value(cdb_value),
      .cdb_src  (cdb_src)
`ifdef CDB_ARB_PERF_EN
      ,
      .grant_count   (grant_count),
      .conflict_count(conflict_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       sq;
      logic [3:0] rv;
      logic [3:0] ack;
      logic       cv;
      logic [1:0] src;
      int         dv;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl[NV];

   function automatic logic [4:0] tag_of(input int v, input int i);
      return 5'((v * 4 + i) & 31);
   endfunction

   function automatic logic [31:0] val_of(input int v, input int i);
      return 32'hA500_0000 | 32'(v << 8) | 32'(i);
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int v, input logic sq,
                        input logic [3:0] rv);
      squash    = sq;
      req_valid = rv;
      for (int i = 0; i < 4; i++) begin
         req_tag[i*5 +: 5]     = tag_of(v, i);
         req_value[i*32 +: 32] = val_of(v, i);
      end
   endtask

   initial begin
      // sq, valid, ack, cdb_valid, cdb_src, data vector
      tbl[0]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 0};
      tbl[1]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 2};
      tbl[3]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 3};
      tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 3};
      tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 5};
      tbl[6]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 6};
      tbl[7]  = '{1'b0, 4'b1001, 4'b0001, 1'b1, 2'd0, 7};
      tbl[8]  = '{1'b1, 4'b0110, 4'b0000, 1'b0, 2'd0, 7};
      tbl[9]  = '{1'b0, 4'b0110, 4'b0010, 1'b1, 2'd1, 9};
      tbl[10] = '{1'b0, 4'b0110, 4'b0100, 1'b1, 2'd2, 10};
      tbl[11] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0, 11};
      tbl[12] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 2'd1, 12};
      tbl[13] = '{1'b0, 4'b1100, 4'b0100, 1'b1, 2'd2, 13};
      tbl[14] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 13};
      tbl[15] = '{1'b0, 4'b1110, 4'b1000, 1'b1, 2'd3, 15};
      tbl[16] = '{1'b0, 4'b1110, 4'b0010, 1'b1, 2'd1, 16};

      reset = 1'b1;
      drive(0, 1'b0, 4'b1111);
      #1 reset = 1'b0;
      #2;
      chk("rst_ack",   64'(req_ack),   64'd0);
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_tag",   64'(cdb_tag),   64'd0);
      chk("rst_value", 64'(cdb_value), 64'd0);
      chk("rst_src",   64'(cdb_src),   64'd0);

      @(negedge clock);
      reset = 1'b1;

      for (int v = 0; v < NV; v++) begin
         drive(v, tbl[v].sq, tbl[v].rv);
         #1;
         chk($sformatf("v%0d_ack", v), 64'(req_ack), 64'(tbl[v].ack));
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_valid", v), 64'(cdb_valid),
             64'(tbl[v].cv));
         chk($sformatf("v%0d_src", v), 64'(cdb_src),
             64'(tbl[v].src));
         chk($sformatf("v%0d_tag", v), 64'(cdb_tag),
             64'(tag_of(tbl[v].dv, int'(tbl[v].src))));
         chk($sformatf("v%0d_value", v), 64'(cdb_value),
             64'(val_of(tbl[v].dv, int'(tbl[v].src))));
         @(negedge clock);
      end

      // Sole requester 2 with a known tag and value.
      drive(20, 1'b0, 4'b0100);
      req_tag[10 +: 5]    = 5'h0A;
      req_value[64 +: 32] = 32'hDEADBEEF;
      #1;
      chk("solo_ack", 64'(req_ack), 64'b0100);
      @(posedge clock);
      #1;
      chk("solo_valid", 64'(cdb_valid), 64'd1);
      chk("solo_tag",   64'(cdb_tag),   64'h0A);
      chk("solo_value", 64'(cdb_value), 64'hDEADBEEF);
      chk("solo_src",   64'(cdb_src),   64'd2);
      @(negedge clock);
      req_valid = 4'b0000;
      @(posedge clock);
      #1;
      chk("idle_valid", 64'(cdb_valid), 64'd0);
      chk("idle_src",   64'(cdb_src),   64'd2);

`ifdef CDB_ARB_PERF_EN
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("perf_rst_g", 64'(grant_count),    64'd0);
      chk("perf_rst_c", 64'(conflict_count), 64'd0);
      drive(30, 1'b0, 4'b0011);
      for (int c = 0; c < 10; c++) begin
         @(posedge clock);
      end
      @(negedge clock);
      req_valid = 4'b0000;
      chk("perf_grant",    64'(grant_count),    64'd10);
      chk("perf_conflict", 64'(conflict_count), 64'd10);
`endif

      // Reset pulse in the middle of continuous requests.
      @(negedge clock);
      drive(40, 1'b0, 4'b1111);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("mid_pre_valid", 64'(cdb_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
      chk("mid_rst_ack",   64'(req_ack),   64'd0);
      chk("mid_rst_src",   64'(cdb_src),   64'd0);
      chk("mid_rst_tag",   64'(cdb_tag),   64'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rel_ack", 64'(req_ack), 64'b0001);
      @(posedge clock);
      #1;
      chk("mid_rel_valid", 64'(cdb_valid), 64'd1);
      chk("mid_rel_src",   64'(cdb_src),   64'd0);
      chk("mid_rel_tag",   64'(cdb_tag),   64'(tag_of(40, 0)));
      @(negedge clock);
      #1;
      chk("mid_next_ack", 64'(req_ack), 64'b0010);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of functional-unit completion requesters (2..8).
REQ-002 SHALL have parameter TAG_W, default 5, meaning ROB tag width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning result value width.
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port squash  input  1  ROB misprediction flush.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester completed result pending.
REQ-008 SHALL have port req_tag  input  N_REQ*TAG_W  per-requester ROB tag; requester i in slice [i*TAG_W +: TAG_W].
REQ-009 SHALL have port req_value  input  N_REQ*DATA_W  per-requester result; requester i in slice [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_ack  output  N_REQ  one-hot grant; requester i may drop or replace its result after the edge.
REQ-011 SHALL have port cdb_valid  output  1  registered CDB broadcast valid.
REQ-012 SHALL have port cdb_tag  output  TAG_W  registered broadcast ROB tag.
REQ-013 SHALL have port cdb_value  output  DATA_W  registered broadcast value.
REQ-014 SHALL have port cdb_src  output  clog2(N_REQ)  index of the requester that produced the current broadcast.

Function
REQ-015 SHALL keep a round-robin pointer ptr (clog2(N_REQ) bits); priority order ptr, ptr+1, ..., ptr-1, modulo N_REQ.
REQ-016 SHALL assert req_ack combinationally, same cycle, for exactly the highest-priority requester with req_valid=1; at most one bit high.
REQ-017 SHALL, on the edge ending a granted cycle, load cdb_valid=1, cdb_tag/cdb_value from the granted slices, and cdb_src=granted index; one-cycle latency from request to broadcast.
REQ-018 SHALL, on the same edge, set ptr to granted index + 1, wrapping from N_REQ-1 to 0.
REQ-019 SHALL, in a cycle with no req_valid bit high, drive req_ack=0 and register cdb_valid=0; ptr holds; cdb_tag, cdb_value and cdb_src hold their previous values.
REQ-020 SHALL, when squash=1, drive req_ack=0 and register cdb_valid=0 on that edge; ptr holds; squash overrides any pending request.
REQ-021 SHALL rely on requesters to hold req_valid, req_tag and req_value stable until acked; an unacked requester is re-arbitrated every cycle.
REQ-022 SHALL grant any continuously requesting requester within N_REQ cycles, with no starvation.
REQ-023 SHALL sustain one broadcast per cycle under continuous demand, with no bubble cycles.

Reset
REQ-024 SHALL, while reset=0 (asynchronous), force ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0 and cdb_src=0, and drive req_ack=0.
REQ-025 SHALL, on reset asserted mid-broadcast, drop the in-flight broadcast; the first grant after release follows ptr=0 priority.

Configuration
REQ-026 SHALL, when macro CDB_ARB_PERF_EN is defined, add outputs grant_count (32 bits; +1 per registered broadcast) and conflict_count (32 bits; +1 per cycle with 2 or more req_valid bits high and squash=0).
REQ-027 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-028 SHALL, when CDB_ARB_PERF_EN is not defined, omit both ports and their logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: after reset, req_valid=4'b1111 held for 4 cycles, with each acked requester re-presenting a new result -> acks 0,1,2,3 in order, cdb_src 0,1,2,3 one cycle later, cdb_valid=1 every cycle.
REQ-030 SHALL cover: ptr=3, req_valid=4'b1001 -> ack requester 3, then requester 0; checks wrap-around.
REQ-031 SHALL cover: requester 2 with tag 5'h0A and value 32'hDEADBEEF is the sole requester -> req_ack=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=0A, cdb_value=DEADBEEF, cdb_src=2.
REQ-032 SHALL cover: squash=1 with req_valid=4'b0110 -> req_ack=0, next-cycle cdb_valid=0, ptr unchanged; requester 1 is acked on the next cycle once squash=0.
REQ-033 SHALL cover: reset driven low for 1 cycle during continuous requests -> cdb_valid=0 immediately; the first grant after release goes to requester 0.
REQ-034 SHALL cover, with CDB_ARB_PERF_EN defined: 10 cycles of req_valid=4'b0011 -> grant_count=10, conflict_count=10.
